// File: rtl/key_pulser_pkg.sv
// Shared types and helpers for the key_pulser button conditioner.
// Imported by key_channel and key_pulser.
package key_pulser_pkg;

   typedef enum logic [1:0] {
      KS_IDLE,
      KS_HELD,
      KS_REPEAT
   } key_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: synchroniser, debounce counter, press/repeat FSM and repeat timer.
// Produces a registered single-cycle pulse on press and on each auto-repeat.
module key_channel
   import key_pulser_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE     = 4,
   parameter int REPEAT_DELAY = 16,
   parameter int REPEAT_RATE  = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic in,
   input  logic repeat_en,
   output logic out,
   output logic held
);

   localparam int TW = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
   localparam int CW = $clog2(DEBOUNCE + 1);
   localparam logic [TW-1:0] DELAY_T  = TW'(REPEAT_DELAY);
   localparam logic [TW-1:0] RATE_T   = TW'(REPEAT_RATE);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   logic [CW-1:0]          cnt;
   logic                   rise;
   logic                   fall;

   key_state_t             state;
   key_state_t             state_nx;
   logic [TW-1:0]          timer;
   logic [TW-1:0]          timer_nx;
   logic [TW-1:0]          timer_inc;
   logic                   pulse_nx;

   assign s = sync[SYNC_STAGES-1];

   // The debounced edge is known one cycle early so the pulse can be registered
   // on the very edge where held toggles.
   assign rise = s & ~held & (cnt == CNT_LAST);
   assign fall = ~s & held & (cnt == CNT_LAST);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync <= '0;
         cnt  <= '0;
         held <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], in};
         if (s == held) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            held <= ~held;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= KS_IDLE;
         timer <= '0;
         out   <= 1'b0;
      end else begin
         state <= state_nx;
         timer <= timer_nx;
         out   <= pulse_nx;
      end
   end

   assign timer_inc = timer + 1'b1;

   // NOTE: every output of this block is given a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nx = state;
      timer_nx = timer;
      pulse_nx = 1'b0;
      case (state)
         KS_IDLE: begin
            if (rise) begin
               state_nx = KS_HELD;
               timer_nx = '0;
               pulse_nx = 1'b1;
            end
         end
         KS_HELD, KS_REPEAT: begin
            // Release wins over a repeat pulse due on the same edge.
            if (fall) begin
               state_nx = KS_IDLE;
               timer_nx = '0;
            end else if (!repeat_en) begin
               state_nx = KS_HELD;
               timer_nx = '0;
            end else if (timer_inc == ((state == KS_HELD) ? DELAY_T : RATE_T)) begin
               state_nx = KS_REPEAT;
               timer_nx = '0;
               pulse_nx = 1'b1;
            end else begin
               timer_nx = timer_inc;
            end
         end
         default: begin
            state_nx = KS_IDLE;
            timer_nx = '0;
         end
      endcase
   end

endmodule

// File: rtl/key_pulser.sv
// N-channel button conditioner for the Frogger input path: one independent
// key_channel per raw key, sharing clock, reset and the auto-repeat enable.
module key_pulser
   import key_pulser_pkg::*;
#(
   parameter int N            = 4,
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE     = 4,
   parameter int REPEAT_DELAY = 16,
   parameter int REPEAT_RATE  = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] in,
   input  logic         repeat_en,
   output logic [N-1:0] out,
   output logic [N-1:0] held
);

   for (genvar i = 0; i < N; i++) begin : g_ch
      key_channel #(
         .SYNC_STAGES  (SYNC_STAGES),
         .DEBOUNCE     (DEBOUNCE),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_RATE  (REPEAT_RATE)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .in        (in[i]),
         .repeat_en (repeat_en),
         .out       (out[i]),
         .held      (held[i])
      );
   end

endmodule

// File: tb/tb_key_pulser.sv
// Self-checking bench for key_pulser with default parameters: expected pulses
// are queued with the edge they must follow and matched as the DUT emits them.
module tb_key_pulser;

   localparam int N = 4;

   typedef struct {
      int         at;
      logic [N-1:0] mask;
   } exp_t;

   logic         clk;
   logic         reset;
   logic [N-1:0] in;
   logic         repeat_en;
   logic [N-1:0] out;
   logic [N-1:0] held;

   int   checks = 0;
   int   errors = 0;
   int   edge_n = 0;
   bit   mon_on = 1'b0;
   exp_t sb[$];

   key_pulser #(
      .N            (N),
      .SYNC_STAGES  (2),
      .DEBOUNCE     (4),
      .REPEAT_DELAY (16),
      .REPEAT_RATE  (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in        (in),
      .repeat_en (repeat_en),
      .out       (out),
      .held      (held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (after edge %0d)", tag, obs, exp, edge_n - 1);
      end
   endtask

   // Returns at the falling edge just after posedge number e (0-based).
   task automatic wait_edge(input int e);
      while (edge_n < e + 1) @(negedge clk);
   endtask

   task automatic expect_pulse(input int at, input logic [N-1:0] mask);
      exp_t x;
      x.at   = at;
      x.mask = mask;
      sb.push_back(x);
   endtask

   // Every nonzero out must match the head of the scoreboard.
   always @(negedge clk) begin
      if (mon_on && out !== '0) begin
         if (sb.size() == 0) begin
            check("unexpected_pulse", 32'(out), 32'd0);
         end else begin
            exp_t x;
            x = sb.pop_front();
            check("pulse_edge", 32'(edge_n - 1), 32'(x.at));
            check("pulse_mask", 32'(out), 32'(x.mask));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e0;
      reset     = 1'b1;
      in        = '0;
      repeat_en = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_out", 32'(out), 32'd0);
      check("reset_held", 32'(held), 32'd0);
      mon_on = 1'b1;
      reset  = 1'b0;
      repeat (3) @(negedge clk);

      // 1: single press, no repeat
      e0 = edge_n;
      in[0] = 1'b1;
      expect_pulse(e0 + 5, 4'b0001);
      wait_edge(e0 + 4);
      check("s1_held_before", 32'(held), 32'd0);
      wait_edge(e0 + 5);
      check("s1_held_rise", 32'(held), 32'b0001);
      wait_edge(e0 + 29);
      in[0] = 1'b0;
      wait_edge(e0 + 34);
      check("s1_held_still", 32'(held), 32'b0001);
      wait_edge(e0 + 35);
      check("s1_held_fall", 32'(held), 32'd0);
      wait_edge(e0 + 40);
      check("s1_sb_empty", 32'(sb.size()), 32'd0);

      // 2: glitch shorter than debounce
      e0 = edge_n;
      in[1] = 1'b1;
      wait_edge(e0 + 2);
      in[1] = 1'b0;
      for (int k = 3; k < 15; k++) begin
         wait_edge(e0 + k);
         check("s2_held_glitch", 32'(held), 32'd0);
      end

      // 3: auto-repeat train and release
      e0 = edge_n;
      repeat_en = 1'b1;
      in[2]     = 1'b1;
      expect_pulse(e0 + 5, 4'b0100);
      expect_pulse(e0 + 21, 4'b0100);
      expect_pulse(e0 + 29, 4'b0100);
      expect_pulse(e0 + 37, 4'b0100);
      expect_pulse(e0 + 45, 4'b0100);
      expect_pulse(e0 + 53, 4'b0100);
      expect_pulse(e0 + 61, 4'b0100);
      wait_edge(e0 + 59);
      in[2] = 1'b0;
      wait_edge(e0 + 64);
      check("s3_held_still", 32'(held), 32'b0100);
      wait_edge(e0 + 65);
      check("s3_held_fall", 32'(held), 32'd0);
      wait_edge(e0 + 75);
      check("s3_sb_empty", 32'(sb.size()), 32'd0);
      repeat_en = 1'b0;

      // 4: simultaneous press on two channels
      e0 = edge_n;
      in = 4'b1001;
      expect_pulse(e0 + 5, 4'b1001);
      wait_edge(e0 + 5);
      check("s4_held_both", 32'(held), 32'b1001);
      wait_edge(e0 + 9);
      in = '0;
      wait_edge(e0 + 20);
      check("s4_held_off", 32'(held), 32'd0);
      check("s4_sb_empty", 32'(sb.size()), 32'd0);

      // 5: reset while a key is held
      e0 = edge_n;
      in[1] = 1'b1;
      expect_pulse(e0 + 5, 4'b0010);
      expect_pulse(e0 + 17, 4'b0010);
      wait_edge(e0 + 9);
      check("s5_held_pre", 32'(held), 32'b0010);
      reset = 1'b1;
      wait_edge(e0 + 10);
      check("s5_rst_out0", 32'(out), 32'd0);
      check("s5_rst_held0", 32'(held), 32'd0);
      wait_edge(e0 + 11);
      check("s5_rst_out1", 32'(out), 32'd0);
      check("s5_rst_held1", 32'(held), 32'd0);
      reset = 1'b0;
      wait_edge(e0 + 16);
      check("s5_held_wait", 32'(held), 32'd0);
      wait_edge(e0 + 17);
      check("s5_held_again", 32'(held), 32'b0010);
      wait_edge(e0 + 19);
      in[1] = 1'b0;
      wait_edge(e0 + 30);
      check("s5_sb_empty", 32'(sb.size()), 32'd0);

      // 6: repeat_en dropped after first repeat, then re-enabled;
      //    release timed so held falls on the edge a repeat is due
      e0 = edge_n;
      repeat_en = 1'b1;
      in[3]     = 1'b1;
      expect_pulse(e0 + 5, 4'b1000);
      expect_pulse(e0 + 21, 4'b1000);
      expect_pulse(e0 + 55, 4'b1000);
      wait_edge(e0 + 21);
      repeat_en = 1'b0;
      wait_edge(e0 + 38);
      check("s6_held_norep", 32'(held), 32'b1000);
      wait_edge(e0 + 39);
      repeat_en = 1'b1;
      wait_edge(e0 + 57);
      in[3] = 1'b0;
      wait_edge(e0 + 62);
      check("s6_held_still", 32'(held), 32'b1000);
      wait_edge(e0 + 63);
      check("s6_held_fall", 32'(held), 32'd0);
      wait_edge(e0 + 75);
      check("s6_sb_empty", 32'(sb.size()), 32'd0);
      check("final_out", 32'(out), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
